// File: rtl/cnn_drv_pkg.sv
// Shared constants, state encoding and load-select codes for the CNN stimulus driver.
package cnn_drv_pkg;

    localparam int IMG_LEN = 75;
    localparam int KER_LEN = 12;
    localparam int WGT_LEN = 24;
    localparam int OUT_LEN = 3;
    localparam int TIMEOUT = 150;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 7;
    localparam int RCNT_W = $clog2(OUT_LEN + 1);

    localparam int ERR_PROTO   = 0;
    localparam int ERR_COUNT   = 1;
    localparam int ERR_TIMEOUT = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        WAIT = 3'd2,
        RECV = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SEL_IMG = 2'd0,
        SEL_K1  = 2'd1,
        SEL_K2  = 2'd2,
        SEL_WGT = 2'd3
    } ld_sel_t;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr, input int depth);
        return addr < ADDR_W'(depth);
    endfunction

endpackage

// File: rtl/cnn_drv_buf.sv
// Pattern word buffer: one write port, one registered read port that returns 0 when idle.
module cnn_drv_buf
    import cnn_drv_pkg::*;
#(
    parameter int DEPTH = IMG_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;
    logic              rd_ok;

    assign wr_ok = wr_en && addr_ok(wr_addr, DEPTH);
    assign rd_ok = rd_en && addr_ok(rd_addr, DEPTH);

    // Contents survive reset so a pattern can be replayed without reloading.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_addr[AW-1:0]] <= wr_data;
    end

    // Write-first on a same-cycle hit, so a load issued with start reaches word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_ok) begin
            rd_data <= (wr_ok && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr[AW-1:0]];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/cnn_stim_driver.sv
// Streams one preloaded pattern into the CNN, then captures and checks its out_valid burst.
//  state | meaning
//  IDLE  | after reset, buffers loadable, waiting for start
//  SEND  | in_valid high, word k of each buffer on the bus
//  WAIT  | counting cycles since last in_valid, waiting for first out_valid
//  RECV  | capturing the remaining output words
//  DONE  | results/errors held, buffers loadable, start reruns
module cnn_stim_driver
    import cnn_drv_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ld_valid,
    input  logic [1:0]                ld_sel,
    input  logic [ADDR_W-1:0]         ld_addr,
    input  logic [DATA_W-1:0]         ld_data,
    input  logic                      opt_cfg,
    input  logic                      start,
    output logic                      in_valid,
    output logic [DATA_W-1:0]         Img,
    output logic [DATA_W-1:0]         Kernel_ch1,
    output logic [DATA_W-1:0]         Kernel_ch2,
    output logic [DATA_W-1:0]         Weight,
    output logic                      Opt,
    input  logic                      out_valid,
    input  logic [DATA_W-1:0]         out,
    output logic [DATA_W*OUT_LEN-1:0] result,
    output logic [7:0]                latency,
    output logic                      done,
    output logic [2:0]                err
);
    state_t            state;
    logic [ADDR_W-1:0] k;
    logic [7:0]        wcnt;
    logic [7:0]        tmr;
    logic [RCNT_W-1:0] rcnt;
    logic [DATA_W-1:0] res [OUT_LEN];

    logic              idle_like;
    logic              start_acc;
    logic              ld_ok;
    logic              send_last;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              we_img, we_k1, we_k2, we_wgt;
    logic              stray_out;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign start_acc = start && idle_like;
    assign ld_ok     = ld_valid && idle_like;
    assign we_img    = ld_ok && (ld_sel == SEL_IMG);
    assign we_k1     = ld_ok && (ld_sel == SEL_K1);
    assign we_k2     = ld_ok && (ld_sel == SEL_K2);
    assign we_wgt    = ld_ok && (ld_sel == SEL_WGT);
    assign send_last = (state == SEND) && (k == ADDR_W'(IMG_LEN - 1));
    assign stray_out = !out_valid && (out != '0);

    // Read the word for the next bus cycle; short buffers return 0 past their depth.
    assign rd_en   = start_acc || ((state == SEND) && !send_last && !out_valid);
    assign rd_addr = start_acc ? '0 : (k + ADDR_W'(1));

    cnn_drv_buf #(.DEPTH(IMG_LEN)) u_img (
        .clk(clk), .rst_n(rst_n), .wr_en(we_img), .wr_addr(ld_addr), .wr_data(ld_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(Img)
    );
    cnn_drv_buf #(.DEPTH(KER_LEN)) u_k1 (
        .clk(clk), .rst_n(rst_n), .wr_en(we_k1), .wr_addr(ld_addr), .wr_data(ld_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(Kernel_ch1)
    );
    cnn_drv_buf #(.DEPTH(KER_LEN)) u_k2 (
        .clk(clk), .rst_n(rst_n), .wr_en(we_k2), .wr_addr(ld_addr), .wr_data(ld_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(Kernel_ch2)
    );
    cnn_drv_buf #(.DEPTH(WGT_LEN)) u_wgt (
        .clk(clk), .rst_n(rst_n), .wr_en(we_wgt), .wr_addr(ld_addr), .wr_data(ld_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(Weight)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_valid <= 1'b0;
            Opt      <= 1'b0;
            k        <= '0;
            wcnt     <= '0;
            tmr      <= '0;
            rcnt     <= '0;
            latency  <= '0;
            done     <= 1'b0;
            err      <= '0;
            for (int i = 0; i < OUT_LEN; i++) res[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_acc) begin
                        state    <= SEND;
                        in_valid <= 1'b1;
                        Opt      <= opt_cfg;
                        k        <= '0;
                        latency  <= '0;
                        done     <= 1'b0;
                        err      <= '0;
                        for (int i = 0; i < OUT_LEN; i++) res[i] <= '0;
                    end
                end
                SEND: begin
                    Opt <= 1'b0;
                    if (out_valid) begin
                        err[ERR_PROTO] <= 1'b1;
                        in_valid       <= 1'b0;
                        done           <= 1'b1;
                        state          <= DONE;
                    end else if (send_last) begin
                        in_valid <= 1'b0;
                        wcnt     <= 8'd1;
                        tmr      <= 8'(TIMEOUT - 1);
                        state    <= WAIT;
                    end else begin
                        k <= k + ADDR_W'(1);
                    end
                end
                WAIT: begin
                    if (stray_out) err[ERR_PROTO] <= 1'b1;
                    if (out_valid) begin
                        latency <= wcnt;
                        res[0]  <= out;
                        rcnt    <= RCNT_W'(1);
                        state   <= RECV;
                    end else if (tmr == '0) begin
                        err[ERR_TIMEOUT] <= 1'b1;
                        done             <= 1'b1;
                        state            <= DONE;
                    end else begin
                        tmr  <= tmr - 8'd1;
                        wcnt <= (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
                    end
                end
                RECV: begin
                    if (stray_out) err[ERR_PROTO] <= 1'b1;
                    if (rcnt < RCNT_W'(OUT_LEN)) begin
                        if (out_valid) begin
                            res[rcnt] <= out;
                            rcnt      <= rcnt + RCNT_W'(1);
                        end else begin
                            err[ERR_COUNT] <= 1'b1;
                            done           <= 1'b1;
                            state          <= DONE;
                        end
                    end else begin
                        // One cycle past the burst: out_valid must have dropped.
                        if (out_valid) err[ERR_COUNT] <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        result = '0;
        for (int i = 0; i < OUT_LEN; i++) result[i*DATA_W +: DATA_W] = res[i];
    end

endmodule

// File: tb/tb_cnn_stim_driver.sv
// Scoreboard bench for cnn_stim_driver: expected bus beats and done records are queued, a monitor checks them.
module tb_cnn_stim_driver;
    localparam int IMG_LEN = 75;
    localparam int KER_LEN = 12;
    localparam int WGT_LEN = 24;

    typedef struct {
        logic [31:0] img;
        logic [31:0] k1;
        logic [31:0] k2;
        logic [31:0] w;
        logic        opt;
    } beat_t;

    typedef struct {
        logic [95:0] res;
        logic [7:0]  lat;
        logic [2:0]  err;
    } done_rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid;
    logic [1:0]  ld_sel;
    logic [6:0]  ld_addr;
    logic [31:0] ld_data;
    logic        opt_cfg;
    logic        start;
    logic        in_valid;
    logic [31:0] Img, Kernel_ch1, Kernel_ch2, Weight;
    logic        Opt;
    logic        out_valid;
    logic [31:0] cnn_out;
    logic [95:0] result;
    logic [7:0]  latency;
    logic        done;
    logic [2:0]  err;

    int tests = 0;
    int fails = 0;

    logic [31:0] img_e [IMG_LEN];
    logic [31:0] k1_e  [KER_LEN];
    logic [31:0] k2_e  [KER_LEN];
    logic [31:0] w_e   [WGT_LEN];

    beat_t     bus_q [$];
    done_rec_t res_q [$];
    logic      prev_done = 1'b0;

    always #5 clk = ~clk;

    cnn_stim_driver dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_addr(ld_addr),
        .ld_data(ld_data), .opt_cfg(opt_cfg), .start(start), .in_valid(in_valid), .Img(Img),
        .Kernel_ch1(Kernel_ch1), .Kernel_ch2(Kernel_ch2), .Weight(Weight), .Opt(Opt),
        .out_valid(out_valid), .out(cnn_out), .result(result), .latency(latency),
        .done(done), .err(err)
    );

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every bus cycle and every done rising edge against the queues.
    always @(negedge clk) begin
        if (in_valid === 1'b1) begin
            if (bus_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL extra_beat: in_valid=1 with no beat expected, Img=%0h (t=%0t)", Img, $time);
            end else begin
                beat_t b;
                b = bus_q.pop_front();
                chk("beat", {Img, Kernel_ch1, Kernel_ch2, Weight, Opt}, {b.img, b.k1, b.k2, b.w, b.opt});
            end
        end else begin
            chk("idle_bus_zero", {Img, Kernel_ch1, Kernel_ch2, Weight, Opt}, '0);
        end
        if (done === 1'b1 && prev_done !== 1'b1) begin
            if (res_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL extra_done: done rose with no record expected, err=%0b (t=%0t)", err, $time);
            end else begin
                done_rec_t r;
                r = res_q.pop_front();
                chk("done_result", result, r.res);
                chk("done_latency", latency, r.lat);
                chk("done_err", err, r.err);
            end
        end
        prev_done <= done;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ld(input logic [1:0] sel, input logic [6:0] addr, input logic [31:0] data);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_addr  = addr;
        ld_data  = data;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic push_beats(input int n, input logic o);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.img = img_e[i];
            b.k1  = (i < KER_LEN) ? k1_e[i] : 32'h0;
            b.k2  = (i < KER_LEN) ? k2_e[i] : 32'h0;
            b.w   = (i < WGT_LEN) ? w_e[i] : 32'h0;
            b.opt = (i == 0) ? o : 1'b0;
            bus_q.push_back(b);
        end
    endtask

    task automatic pulse_start(input logic o, input bit do_ld, input logic [31:0] d);
        opt_cfg = o;
        start   = 1'b1;
        if (do_ld) begin
            ld_valid = 1'b1;
            ld_sel   = 2'd0;
            ld_addr  = 7'd0;
            ld_data  = d;
        end
        tick();
        start    = 1'b0;
        ld_valid = 1'b0;
        chk("start_in_valid", in_valid, 1);
        chk("start_clears", {done, err}, 0);
    endtask

    task automatic run_pattern(input string name, input logic o, input int delay, input int nwords,
                               input int glitch_at, input bit poke, input bit do_ld,
                               input logic [31:0] ldd, input logic [95:0] eres,
                               input logic [7:0] elat, input logic [2:0] eerr);
        logic [31:0] vals [4];
        done_rec_t   r;
        int          cyc;
        int          n;
        vals = '{32'hA, 32'hB, 32'hC, 32'hD};
        if (do_ld) img_e[0] = ldd;
        push_beats(IMG_LEN, o);
        r.res = eres;
        r.lat = elat;
        r.err = eerr;
        res_q.push_back(r);
        pulse_start(o, do_ld, ldd);
        n = 0;
        while (in_valid === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_send_len"}, n, IMG_LEN);
        cyc = 1;
        if (poke) begin
            start    = 1'b1;
            ld_valid = 1'b1;
            ld_sel   = 2'd0;
            ld_addr  = 7'd0;
            ld_data  = 32'hBAD;
            tick();
            cyc++;
            start    = 1'b0;
            ld_valid = 1'b0;
        end
        if (glitch_at > 0) begin
            while (cyc < glitch_at) begin
                tick();
                cyc++;
            end
            cnn_out = 32'h5;
            tick();
            cyc++;
            cnn_out = 32'h0;
        end
        if (delay > 0) begin
            while (cyc < delay) begin
                tick();
                cyc++;
            end
            for (int w = 0; w < nwords; w++) begin
                out_valid = 1'b1;
                cnn_out   = vals[w];
                tick();
                cyc++;
            end
            out_valid = 1'b0;
            cnn_out   = 32'h0;
        end
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            tick();
            cyc++;
            n++;
        end
        chk({name, "_done"}, done, 1);
        if (delay == 0) chk({name, "_timeout_cycle"}, cyc, 151);
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        ld_valid  = 1'b0;
        ld_sel    = 2'd0;
        ld_addr   = 7'd0;
        ld_data   = 32'h0;
        opt_cfg   = 1'b0;
        start     = 1'b0;
        out_valid = 1'b0;
        cnn_out   = 32'h0;
        #1;
        chk("rst_bus", {in_valid, Img, Kernel_ch1, Kernel_ch2, Weight, Opt}, '0);
        chk("rst_status", {result, latency, done, err}, '0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < IMG_LEN; i++) begin img_e[i] = 32'(i);         ld(2'd0, 7'(i), img_e[i]); end
        for (int i = 0; i < KER_LEN; i++) begin k1_e[i]  = 32'h100 + 32'(i); ld(2'd1, 7'(i), k1_e[i]); end
        for (int i = 0; i < KER_LEN; i++) begin k2_e[i]  = 32'h200 + 32'(i); ld(2'd2, 7'(i), k2_e[i]); end
        for (int i = 0; i < WGT_LEN; i++) begin w_e[i]   = 32'h300 + 32'(i); ld(2'd3, 7'(i), w_e[i]);  end
        // Out-of-range writes must be dropped, not aliased onto low words.
        ld(2'd0, 7'd80, 32'hFFFF_0080);
        ld(2'd1, 7'd16, 32'hFFFF_0016);
        ld(2'd3, 7'd24, 32'hFFFF_0024);

        run_pattern("basic", 1'b1, 20, 3, 0, 1'b1, 1'b0, 32'h0,
                    {32'hC, 32'hB, 32'hA}, 8'd20, 3'b000);
        run_pattern("timeout", 1'b0, 0, 0, 0, 1'b0, 1'b0, 32'h0,
                    96'h0, 8'd0, 3'b100);
        run_pattern("short", 1'b0, 7, 2, 0, 1'b0, 1'b0, 32'h0,
                    {32'h0, 32'hB, 32'hA}, 8'd7, 3'b010);
        run_pattern("long", 1'b1, 3, 4, 0, 1'b0, 1'b0, 32'h0,
                    {32'hC, 32'hB, 32'hA}, 8'd3, 3'b010);
        run_pattern("stray", 1'b0, 20, 3, 5, 1'b0, 1'b0, 32'h0,
                    {32'hC, 32'hB, 32'hA}, 8'd20, 3'b001);
        run_pattern("lat_max", 1'b0, 150, 3, 0, 1'b0, 1'b0, 32'h0,
                    {32'hC, 32'hB, 32'hA}, 8'd150, 3'b000);

        begin : send_abort
            done_rec_t r;
            int n;
            push_beats(11, 1'b1);
            r.res = 96'h0;
            r.lat = 8'd0;
            r.err = 3'b001;
            res_q.push_back(r);
            pulse_start(1'b1, 1'b0, 32'h0);
            repeat (10) tick();
            out_valid = 1'b1;
            cnn_out   = 32'h77;
            tick();
            out_valid = 1'b0;
            cnn_out   = 32'h0;
            chk("abort_in_valid", in_valid, 0);
            n = 0;
            while (done !== 1'b1 && n < 20) begin tick(); n++; end
            chk("abort_done", done, 1);
            tick();
        end

        begin : mid_reset
            push_beats(IMG_LEN, 1'b1);
            pulse_start(1'b1, 1'b0, 32'h0);
            repeat (30) tick();
            rst_n = 1'b0;
            #1;
            chk("mrst_bus", {in_valid, Img, Kernel_ch1, Kernel_ch2, Weight, Opt}, '0);
            chk("mrst_status", {result, latency, done, err}, '0);
            chk("mrst_beats_left", bus_q.size(), IMG_LEN - 30);
            bus_q.delete();
            tick();
            tick();
            rst_n = 1'b1;
            tick();
        end

        run_pattern("replay", 1'b1, 20, 3, 0, 1'b0, 1'b0, 32'h0,
                    {32'hC, 32'hB, 32'hA}, 8'd20, 3'b000);
        run_pattern("ld_start", 1'b0, 1, 3, 0, 1'b0, 1'b1, 32'hDEAD,
                    {32'hC, 32'hB, 32'hA}, 8'd1, 3'b000);

        repeat (3) tick();
        chk("queues_drained", {bus_q.size(), res_q.size()}, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
